// File: rtl/imem_fetch_seq.sv
// Byte-serial instruction fetch sequencer: four big-endian byte reads per word, valid/ready to decode.
// Optional PC range check enabled by defining IMEM_BOUNDS_CHECK_EN.
module imem_fetch_seq #(
  parameter int unsigned MEM_BYTES = 1000,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [31:0] MADDR,
  output logic        MRD,
  input  logic [7:0]  MDATA,
  input  logic        BR_EN,
  input  logic [31:0] BR_TGT,
  output logic [31:0] INS,
  output logic [31:0] PC_OUT,
  output logic        VALID,
  input  logic        READY,
  output logic        ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
`ifdef IMEM_BOUNDS_CHECK_EN
    , S_FAULT
`endif
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [2:0]  r_icnt;
  logic [1:0]  r_rcnt;
  logic        r_pend;
  logic [31:0] r_ins;
  logic [31:0] r_pc_out;

  logic        w_issue;
  logic        w_capture;
  logic        w_last;
  logic        w_hs;
  logic        w_oob;
  logic        w_unused;

  assign w_unused = ^BR_TGT[1:0];

  always_comb begin
    w_oob = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
    w_oob = (r_state == S_FETCH) && (r_icnt == 3'd0) && ((r_pc + 32'd3) >= MEM_BYTES);
`endif
    w_hs      = (r_state == S_HOLD) && READY;
    w_issue   = (r_state == S_FETCH) && (r_icnt < 3'd4) && !w_oob;
    // r_pend tags a byte whose read was issued since the last redirect
    w_capture = r_pend && !BR_EN;
    w_last    = w_capture && (r_rcnt == 2'd3);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_FETCH;
      S_FETCH: begin
`ifdef IMEM_BOUNDS_CHECK_EN
        if (w_oob)
          w_next = S_FAULT;
        else
`endif
        if (w_last)
          w_next = S_HOLD;
      end
      S_HOLD:  if (READY) w_next = S_FETCH;
      default: w_next = r_state;
    endcase
    if (BR_EN)
      w_next = S_FETCH;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc     <= RESET_PC;
      r_icnt   <= '0;
      r_rcnt   <= '0;
      r_pend   <= 1'b0;
      r_ins    <= '0;
      r_pc_out <= RESET_PC;
    end else if (BR_EN) begin
      r_pc   <= {BR_TGT[31:2], 2'b00};
      r_icnt <= '0;
      r_rcnt <= '0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_issue)
        r_icnt <= r_icnt + 3'd1;
      if (w_capture) begin
        case (r_rcnt)
          2'd0:    r_ins[31:24] <= MDATA;
          2'd1:    r_ins[23:16] <= MDATA;
          2'd2:    r_ins[15:8]  <= MDATA;
          default: r_ins[7:0]   <= MDATA;
        endcase
        r_rcnt <= r_rcnt + 2'd1;
      end
      if (w_last || w_oob)
        r_pc_out <= r_pc;
      if (w_hs) begin
        r_pc   <= r_pc + 32'd4;
        r_icnt <= '0;
      end
    end
  end

  assign MADDR  = r_pc + {30'd0, r_icnt[1:0]};
  assign MRD    = w_issue;
  assign INS    = r_ins;
  assign PC_OUT = r_pc_out;
  assign VALID  = (r_state == S_HOLD);
`ifdef IMEM_BOUNDS_CHECK_EN
  assign ERR    = (r_state == S_FAULT);
`else
  assign ERR    = 1'b0;
`endif

endmodule
